// File: rtl/uart_loader.sv
`timescale 1ns/1ps
// uart_loader: parses a SYNC/ADDR/LEN/payload/CHK byte frame from the UART receiver and
// writes the payload to RAM as 16-bit (or trailing 8-bit) writes while holding the core in reset.
module uart_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TIMEOUT_W      = 17
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_rx_data_ready,
    input  logic [7:0]  I_rx_data,
    input  logic        I_MEM_ready,
    input  logic        I_MEM_data_ready,
    output logic        O_MEM_exec,
    output logic        O_MEM_write,
    output logic [1:0]  O_MEM_size,
    output logic [15:0] O_MEM_addr,
    output logic [15:0] O_MEM_data_out,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_error,
    output logic        O_hold_core
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_LO = 4'd1,
        S_ADDR_HI = 4'd2,
        S_LEN_LO  = 4'd3,
        S_LEN_HI  = 4'd4,
        S_DATA_LO = 4'd5,
        S_DATA_HI = 4'd6,
        S_REQ     = 4'd7,
        S_WAIT    = 4'd8,
        S_CHECK   = 4'd9
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_t               r_state, w_state_nxt;
    logic                 r_buf_valid;
    logic [7:0]           r_buf_data;
    logic [15:0]          r_addr, w_addr_nxt;
    logic [15:0]          r_remain, w_remain_nxt;
    logic [7:0]           r_chk, w_chk_nxt;
    logic [15:0]          r_data, w_data_nxt;
    logic [1:0]           r_size, w_size_nxt;
    logic                 r_exec, w_exec_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic [TIMEOUT_W-1:0] r_timer, w_timer_nxt;

    logic                 w_byte_state;
    logic                 w_consume;
    logic                 w_overrun;
    logic                 w_timeout;
    logic [TIMEOUT_W-1:0] w_timer_inc;
    logic [15:0]          w_remain_dec;

    // The buffer is only drained in states that take a byte; REQ/WAIT leave it parked.
    assign w_byte_state = (r_state != S_REQ) && (r_state != S_WAIT);
    assign w_consume    = r_buf_valid && w_byte_state;
    assign w_overrun    = I_rx_data_ready && r_buf_valid && !w_consume;
    assign w_timer_inc  = r_timer + TIMEOUT_W'(1);
    assign w_timeout    = (r_state != S_IDLE) && w_byte_state && !w_consume
                          && (w_timer_inc == TIMEOUT_LIMIT);
    assign w_remain_dec = r_remain - ((r_size == 2'd1) ? 16'd2 : 16'd1);

    // Single-entry receive byte buffer with valid flag.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= 8'h00;
        end else if (w_overrun) begin
            r_buf_valid <= 1'b0;
        end else if (I_rx_data_ready) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= I_rx_data;
        end else if (w_consume) begin
            r_buf_valid <= 1'b0;
        end else begin
            r_buf_valid <= r_buf_valid;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            r_state  <= S_IDLE;
            r_addr   <= 16'h0000;
            r_remain <= 16'h0000;
            r_chk    <= 8'h00;
            r_data   <= 16'h0000;
            r_size   <= 2'd0;
            r_exec   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_remain <= w_remain_nxt;
            r_chk    <= w_chk_nxt;
            r_data   <= w_data_nxt;
            r_size   <= w_size_nxt;
            r_exec   <= w_exec_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_chk_nxt    = r_chk;
        w_data_nxt   = r_data;
        w_size_nxt   = r_size;
        w_exec_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_error_nxt  = r_error;
        if ((r_state == S_IDLE) || !w_byte_state || w_consume) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = w_timer_inc;
        end

        case (r_state)
            S_REQ: begin
                if (I_MEM_ready) begin
                    w_exec_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_exec_nxt  = 1'b0;
                end
            end
            S_WAIT: begin
                if (I_MEM_data_ready) begin
                    w_addr_nxt   = r_addr + 16'd2;
                    w_remain_nxt = w_remain_dec;
                    w_state_nxt  = (w_remain_dec == 16'd0) ? S_CHECK : S_DATA_LO;
                end else begin
                    w_state_nxt  = S_WAIT;
                end
            end
            default: begin
                if (w_consume) begin
                    case (r_state)
                        S_IDLE: begin
                            if (r_buf_data == SYNC_BYTE) begin
                                w_busy_nxt  = 1'b1;
                                w_done_nxt  = 1'b0;
                                w_error_nxt = 1'b0;
                                w_chk_nxt   = 8'h00;
                                w_state_nxt = S_ADDR_LO;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                        S_ADDR_LO: begin
                            w_addr_nxt  = {r_addr[15:8], r_buf_data};
                            w_state_nxt = S_ADDR_HI;
                        end
                        S_ADDR_HI: begin
                            w_addr_nxt  = {r_buf_data, r_addr[7:0]};
                            w_state_nxt = S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            w_remain_nxt = {r_remain[15:8], r_buf_data};
                            w_state_nxt  = S_LEN_HI;
                        end
                        S_LEN_HI: begin
                            w_remain_nxt = {r_buf_data, r_remain[7:0]};
                            w_state_nxt  = ({r_buf_data, r_remain[7:0]} == 16'd0) ? S_CHECK : S_DATA_LO;
                        end
                        S_DATA_LO: begin
                            w_chk_nxt  = r_chk + r_buf_data;
                            w_data_nxt = {8'h00, r_buf_data};
                            if (r_remain == 16'd1) begin
                                w_size_nxt  = 2'd0;
                                w_state_nxt = S_REQ;
                            end else begin
                                w_state_nxt = S_DATA_HI;
                            end
                        end
                        S_DATA_HI: begin
                            w_chk_nxt   = r_chk + r_buf_data;
                            w_data_nxt  = {r_buf_data, r_data[7:0]};
                            w_size_nxt  = 2'd1;
                            w_state_nxt = S_REQ;
                        end
                        S_CHECK: begin
                            if (r_buf_data == r_chk) begin
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_error_nxt = 1'b1;
                            end
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = r_state;
                end
            end
        endcase

        // Aborts override everything; completed writes are left in place.
        if (w_overrun || w_timeout) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_exec_nxt  = 1'b0;
        end else begin
            w_timer_nxt = w_timer_nxt;
        end
    end

    assign O_MEM_exec     = r_exec;
    assign O_MEM_write    = r_busy;
    assign O_MEM_size     = r_size;
    assign O_MEM_addr     = r_addr;
    assign O_MEM_data_out = r_data;
    assign O_busy         = r_busy;
    assign O_done         = r_done;
    assign O_error        = r_error;
    assign O_hold_core    = r_busy;

endmodule

// File: tb/tb_uart_loader.sv
`timescale 1ns/1ps
// Bench for uart_loader: directed and random frames; expected MEM writes are queued by a
// frame-level model and popped by an independent monitor when O_MEM_exec fires.
module tb_uart_loader;
    localparam int TO_CYCLES = 300;

    logic        I_clk;
    logic        I_reset;
    logic        I_rx_data_ready;
    logic [7:0]  I_rx_data;
    logic        I_MEM_ready;
    logic        I_MEM_data_ready;
    logic        O_MEM_exec;
    logic        O_MEM_write;
    logic [1:0]  O_MEM_size;
    logic [15:0] O_MEM_addr;
    logic [15:0] O_MEM_data_out;
    logic        O_busy;
    logic        O_done;
    logic        O_error;
    logic        O_hold_core;

    logic        resp_ready;
    logic        hold_low;
    bit          long_lat;
    int          n_pass;
    int          n_total;
    logic [33:0] exp_q[$];
    logic [7:0]  pl[0:15];

    assign I_MEM_ready = resp_ready & ~hold_low;

    uart_loader #(
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO_CYCLES), .TIMEOUT_W(9)
    ) dut (
        .I_clk(I_clk), .I_reset(I_reset),
        .I_rx_data_ready(I_rx_data_ready), .I_rx_data(I_rx_data),
        .I_MEM_ready(I_MEM_ready), .I_MEM_data_ready(I_MEM_data_ready),
        .O_MEM_exec(O_MEM_exec), .O_MEM_write(O_MEM_write), .O_MEM_size(O_MEM_size),
        .O_MEM_addr(O_MEM_addr), .O_MEM_data_out(O_MEM_data_out),
        .O_busy(O_busy), .O_done(O_done), .O_error(O_error), .O_hold_core(O_hold_core)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge I_clk);
        #1;
    endtask

    function automatic int gap();
        return int'($urandom_range(15, 8));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int g);
        tick(g);
        I_rx_data       = b;
        I_rx_data_ready = 1'b1;
        tick(1);
        I_rx_data_ready = 1'b0;
    endtask

    // Frame-level model: payload bytes pair up little-endian, an odd tail is a byte write.
    task automatic push_expect(input logic [15:0] a, input int n);
        logic [15:0] wa = a;
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) exp_q.push_back({wa, pl[i+1], pl[i], 2'd1});
            else           exp_q.push_back({wa, 8'h00, pl[i], 2'd0});
            wa = wa + 16'd2;
        end
    endtask

    task automatic send_header(input logic [15:0] a, input int n);
        send_byte(8'hA5, gap());
        tick(2);
        check("flags_after_sync", 64'({O_busy, O_hold_core, O_done, O_error}), 64'(4'b1100));
        send_byte(a[7:0], gap());
        send_byte(a[15:8], gap());
        send_byte(8'(n), gap());
        send_byte(8'(n >> 8), gap());
    endtask

    task automatic run_frame(input logic [15:0] a, input int n, input bit bad, input bit stall);
        logic [7:0] sum = 8'h00;
        push_expect(a, n);
        for (int i = 0; i < n; i++) sum = sum + pl[i];
        send_header(a, n);
        for (int i = 0; i < n; i++) begin
            if (stall && i == 1) hold_low = 1'b1;
            send_byte(pl[i], (stall && i == 2) ? 20 : (stall ? 40 : gap()));
            if (stall && i == 2) begin
                tick(32);
                hold_low = 1'b0;
            end
        end
        send_byte(bad ? ~sum : sum, gap());
        tick(12);
        check("flags_end", 64'({O_busy, O_hold_core, O_done, O_error}), 64'({2'b00, ~bad, bad}));
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        tick(5);
    endtask

    // Responder: accepts a request, drops ready, and completes after a random latency.
    initial begin : responder
        int lat;
        resp_ready       = 1'b1;
        I_MEM_data_ready = 1'b0;
        forever begin
            @(posedge I_clk);
            #1;
            if (O_MEM_exec) begin
                resp_ready = 1'b0;
                lat = long_lat ? 20 : int'($urandom_range(4, 1));
                repeat (lat) @(posedge I_clk);
                #1 I_MEM_data_ready = 1'b1;
                @(posedge I_clk);
                #1 I_MEM_data_ready = 1'b0;
                resp_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expected writes on O_MEM_exec and tracks request stability to completion.
    initial begin : monitor
        bit          prev_exec;
        bit          prev_ready;
        bit          tracking;
        bit          stable;
        logic [33:0] snap;
        logic [33:0] e;
        prev_exec = 1'b0; prev_ready = 1'b0; tracking = 1'b0; stable = 1'b0; snap = '0;
        forever begin
            @(negedge I_clk);
            if (!I_reset) begin
                tracking  = 1'b0;
                prev_exec = 1'b0;
            end else begin
                if (tracking && !O_busy) tracking = 1'b0;
                if (tracking) begin
                    if ({O_MEM_addr, O_MEM_data_out, O_MEM_size} !== snap || O_MEM_write !== 1'b1)
                        stable = 1'b0;
                    if (I_MEM_data_ready) begin
                        check("req_stable", 64'(stable), 64'd1);
                        tracking = 1'b0;
                    end
                end
                if (O_MEM_exec) begin
                    check("exec_single_cycle", 64'(prev_exec), 64'd0);
                    check("exec_with_ready", 64'(prev_ready), 64'd1);
                    check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("write", 64'({O_MEM_write, O_MEM_addr, O_MEM_data_out, O_MEM_size}),
                              64'({1'b1, e}));
                    end
                    tracking = 1'b1;
                    stable   = 1'b1;
                    snap     = {O_MEM_addr, O_MEM_data_out, O_MEM_size};
                end
                prev_exec = O_MEM_exec;
            end
            prev_ready = I_MEM_ready;
        end
    end

    initial begin : main
        int n;
        n_pass = 0; n_total = 0;
        hold_low = 1'b0; long_lat = 1'b0;
        I_reset = 1'b0; I_rx_data_ready = 1'b0; I_rx_data = 8'h00;
        tick(3);
        check("reset_outputs", 64'({O_MEM_exec, O_MEM_write, O_MEM_size, O_MEM_addr, O_MEM_data_out,
                                    O_busy, O_done, O_error, O_hold_core}), 64'd0);
        I_reset = 1'b1;
        tick(3);

        send_byte(8'h12, 5);
        send_byte(8'h34, 5);
        tick(3);
        check("junk_ignored", 64'({O_busy, O_done, O_error}), 64'd0);
        run_frame(16'h0000, 0, 1'b0, 1'b0);

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        run_frame(16'h0100, 4, 1'b0, 1'b0);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        run_frame(16'h0010, 3, 1'b0, 1'b0);
        pl[0] = 8'h01; pl[1] = 8'h02;
        run_frame(16'h0000, 2, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
        run_frame(16'hFFFE, 4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
        run_frame(16'h0200, 5, 1'b0, 1'b1);

        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(9, 0));
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
            run_frame(16'($urandom), n, ($urandom_range(3, 0) == 0), 1'b0);
        end

        // Stream stops after ADDR_HI.
        send_byte(8'hA5, gap());
        send_byte(8'h00, gap());
        send_byte(8'h06, gap());
        tick(TO_CYCLES - 40);
        check("timeout_not_yet", 64'({O_busy, O_error}), 64'(2'b10));
        tick(80);
        check("timeout_abort", 64'({O_busy, O_hold_core, O_done, O_error}), 64'(4'b0001));
        tick(5);

        // Two bytes land while a write is outstanding.
        long_lat = 1'b1;
        pl[0] = 8'h5C; pl[1] = 8'hC5;
        push_expect(16'h0300, 2);
        send_header(16'h0300, 2);
        send_byte(pl[0], gap());
        send_byte(pl[1], gap());
        send_byte(8'h77, 4);
        send_byte(8'h88, 2);
        tick(3);
        check("overrun_abort", 64'({O_busy, O_hold_core, O_done, O_error}), 64'(4'b0001));
        tick(30);

        // Reset while the write is in WAIT.
        pl[0] = 8'hBE; pl[1] = 8'hEF;
        push_expect(16'h0400, 2);
        send_header(16'h0400, 4);
        send_byte(pl[0], gap());
        send_byte(pl[1], gap());
        tick(6);
        I_reset = 1'b0;
        #1;
        check("reset_mid_wait", 64'({O_MEM_exec, O_MEM_write, O_MEM_size, O_MEM_addr, O_MEM_data_out,
                                     O_busy, O_done, O_error, O_hold_core}), 64'd0);
        check("write_before_reset", 64'(exp_q.size()), 64'd0);
        tick(3);
        I_reset = 1'b1;
        tick(30);
        long_lat = 1'b0;

        pl[0] = 8'h9A; pl[1] = 8'h3B; pl[2] = 8'h7E;
        run_frame(16'h0500, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Bus initiator that boots a program image from the UART receive path into RAM before the core runs.
- Parses a byte-framed download from uart_rx and issues word writes on the MEM_* request/response bus, using the same protocol the core drives as initiator.
- Holds the core in reset while a frame is in progress.
- The top level muxes the MEM request lines between this block and the core using O_hold_core.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame before the frame is aborted.
- TIMEOUT_W, 17, width of the inter-byte timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- I_clk  in  1  clock
- I_reset  in  1  asynchronous, active-low reset
- I_rx_data_ready  in  1  one-cycle pulse from uart_rx: byte valid
- I_rx_data  in  8  received byte, valid with I_rx_data_ready
- I_MEM_ready  in  1  responder idle, request accepted when high
- I_MEM_data_ready  in  1  one-cycle completion pulse from responder
- O_MEM_exec  out  1  request strobe
- O_MEM_write  out  1  always 1 while this block owns the bus
- O_MEM_size  out  2  2'd1 = 16-bit word write; 2'd0 = byte write
- O_MEM_addr  out  16  write address
- O_MEM_data_out  out  16  write data
- O_busy  out  1  frame in progress
- O_done  out  1  last frame completed with a good checksum
- O_error  out  1  last frame failed (checksum, timeout or overrun)
- O_hold_core  out  1  equals O_busy

Behaviour:
- Reset (I_reset low, async):
  - Every output goes to 0: O_MEM_exec, O_MEM_write, O_MEM_size, O_MEM_addr, O_MEM_data_out, O_busy, O_done, O_error, O_hold_core.
  - FSM returns to IDLE; the byte buffer is cleared.
  - Reset mid-write abandons the transfer. No completion is awaited.
- Frame format, in this byte order:
  - SYNC_BYTE.
  - ADDR_LO, ADDR_HI.
  - LEN_LO, LEN_HI. LEN is a byte count N, 0..65535.
  - N payload bytes.
  - CHK = 8-bit sum of the payload bytes, mod 256.
- Byte buffer:
  - One entry with a valid flag, loaded on I_rx_data_ready.
  - If a pulse arrives while the buffer is valid and is not being consumed in the same cycle, it is an overrun: set O_error, go to IDLE.
- FSM states: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA_LO, DATA_HI, REQ, WAIT, CHECK.
- IDLE:
  - Bytes other than SYNC_BYTE are discarded.
  - On SYNC_BYTE: O_busy=1, O_done=0, O_error=0, checksum=0, then go to ADDR_LO.
- Header states: each state consumes one byte.
  - After LEN_HI, N=0 goes directly to CHECK.
- DATA_LO and DATA_HI (payload packing):
  - The first byte of a pair is the data low byte, the second is the high byte; each byte is added to the checksum.
  - A complete pair goes to REQ with size 2'd1.
  - If the remaining count reaches 0 after a LO byte (N odd), go to REQ with size 2'd0, data = {8'h00, byte}.
- REQ:
  - Wait for I_MEM_ready=1, then assert O_MEM_exec for exactly one cycle and go to WAIT.
  - Address, data, size and write stay stable from REQ entry until the I_MEM_data_ready pulse.
- WAIT:
  - On I_MEM_data_ready: O_MEM_addr += 2 (16-bit wrap from 16'hFFFE to 16'h0000) and the remaining count decrements.
  - Remaining count 0 goes to CHECK; otherwise go to DATA_LO.
  - Incoming bytes are buffered meanwhile.
- CHECK: consumes the CHK byte.
  - Match: O_done=1.
  - Mismatch: O_error=1.
  - In both cases O_busy=0, then IDLE.
- Flag lifetime: O_done and O_error stay level until the next SYNC_BYTE or reset.
- Timeout:
  - The counter clears on every consumed byte and runs in every state except IDLE, REQ and WAIT.
  - Reaching TIMEOUT_CYCLES gives O_error=1, O_busy=0, IDLE. Writes already completed are not undone.
- Simultaneous events: an I_rx_data_ready in the same cycle as I_MEM_data_ready is buffered normally.

Test Plan:
- A5 00 01 04 00 11 22 33 44 AA → two word writes:
  - 16'h2211 to 16'h0100, then 16'h4433 to 16'h0102, both with size 1.
  - O_done=1, O_error=0, O_busy=0 after the last byte.
- A5 10 00 03 00 01 02 03 06 → 16'h0201 to 16'h0010 with size 1, then 16'h0003 to 16'h0012 with size 0; O_done=1.
- A5 00 00 02 00 01 02 FF (bad checksum) → one write; O_error=1, O_done=0.
- A5 00 00 00 00 00 → no MEM traffic; O_done=1. Leading junk bytes 12 34 before the sync byte are ignored.
- I_MEM_ready held low 50 cycles with the responder delaying data_ready 3 cycles while the next payload byte arrives:
  - O_MEM_exec is a single-cycle pulse that rises only when ready is high.
  - Address and data stay stable; the buffered byte is not lost.
- Stop the stream after ADDR_HI for TIMEOUT_CYCLES → O_error=1, O_busy=0. Assert I_reset low mid-WAIT → all outputs 0 immediately.
